kmp_failure_func: RTL

- Builds the KMP failure (longest-proper-prefix-suffix) table for one pattern.
- Sits directly upstream of the KMP processing elements and drives their `ff_result` bus.
- Computes the table with one byte comparison per cycle, then holds it stable with `output_valid` high.
- The controller can start the processing elements on `output_valid` and share the one table across all of them.

---
 rtl/kmp_failure_func_pkg.sv | 26 ++
 rtl/kmp_failure_func.sv | 118 +++++++++++
 2 files changed

// File: rtl/kmp_failure_func_pkg.sv
// Shared sizing, FSM encodings and helpers for the KMP failure-function builder.
package kmp_failure_func_pkg;

    // Bits per pattern character.
    localparam int BYTE        = 8;
    // Pattern buffer depth in characters.
    localparam int MAX_PATTERN = 8;
    // Width of a pattern index (and of each failure-table entry).
    localparam int MAX_PAT_ADD = 3;

    // One-hot-ish encodings shared with the processing elements.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_INIT = 3'b001,
        ST_COMP = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    // Clamp the requested last index to the physical buffer depth.
    function automatic logic [MAX_PAT_ADD-1:0] clamp_last(input logic [MAX_PAT_ADD-1:0] last);
        if (int'(last) > MAX_PATTERN - 1)
            return MAX_PAT_ADD'(MAX_PATTERN - 1);
        return last;
    endfunction

endpackage

// File: rtl/kmp_failure_func.sv
// KMP failure (longest proper prefix-suffix) table builder. One character
// comparison per cycle; the finished table is held with output_valid high
// until the requester drops input_valid.
module kmp_failure_func
    import kmp_failure_func_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MAX_PATTERN*BYTE-1:0]        pat_input,
    input  logic [MAX_PAT_ADD-1:0]             pat_last_idx,
    input  logic                               input_valid,
    output logic                               output_valid,
    output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result
);

    state_t                 state_reg;
    logic [MAX_PAT_ADD-1:0] i_reg;
    logic [MAX_PAT_ADD-1:0] len_reg;
    logic [MAX_PAT_ADD-1:0] last_reg;
    logic [MAX_PAT_ADD-1:0] ff_reg [MAX_PATTERN];
    logic                   output_valid_reg;

    logic [BYTE-1:0]        char_i;
    logic [BYTE-1:0]        char_len;
    logic                   chars_match;
    logic [MAX_PAT_ADD-1:0] ff_back;
    logic [MAX_PAT_ADD-1:0] i_next;
    logic [MAX_PAT_ADD-1:0] len_next;
    logic [MAX_PAT_ADD-1:0] last_clamped;
    logic                   at_last;

    // Compare datapath: current candidate character against the prefix character.
    always_comb begin
        char_i       = pat_input[i_reg*BYTE +: BYTE];
        char_len     = pat_input[len_reg*BYTE +: BYTE];
        chars_match  = (char_i == char_len);
        // Only consumed when len_reg != 0, so the wrap at len_reg == 0 is harmless.
        ff_back      = ff_reg[len_reg - 1'b1];
        i_next       = i_reg + 1'b1;
        len_next     = len_reg + 1'b1;
        last_clamped = clamp_last(pat_last_idx);
        at_last      = (i_reg == last_reg);
    end

    // Control FSM plus failure-table writes; everything is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            output_valid_reg <= 1'b0;
            i_reg            <= MAX_PAT_ADD'(1);
            len_reg          <= '0;
            last_reg         <= '0;
            for (int k = 0; k < MAX_PATTERN; k++)
                ff_reg[k] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (input_valid)
                        state_reg <= ST_INIT;
                end
                ST_INIT: begin
                    for (int k = 0; k < MAX_PATTERN; k++)
                        ff_reg[k] <= '0;
                    i_reg    <= MAX_PAT_ADD'(1);
                    len_reg  <= '0;
                    last_reg <= last_clamped;
                    if (last_clamped == '0) begin
                        state_reg        <= ST_DONE;
                        output_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_COMP;
                    end
                end
                ST_COMP: begin
                    if (chars_match) begin
                        ff_reg[i_reg] <= len_next;
                        len_reg       <= len_next;
                        i_reg         <= i_next;
                        if (at_last) begin
                            state_reg        <= ST_DONE;
                            output_valid_reg <= 1'b1;
                        end
                    end else if (len_reg != '0) begin
                        // Fall back along the table; i stays put for a retry.
                        len_reg <= ff_back;
                    end else begin
                        ff_reg[i_reg] <= '0;
                        i_reg         <= i_next;
                        if (at_last) begin
                            state_reg        <= ST_DONE;
                            output_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!input_valid) begin
                        state_reg        <= ST_IDLE;
                        output_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= ST_IDLE;
                    output_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign output_valid = output_valid_reg;

    // Flatten the table onto the processing-element bus.
    generate
        for (genvar gi = 0; gi < MAX_PATTERN; gi++) begin : g_ff_out
            assign ff_result[gi*MAX_PAT_ADD +: MAX_PAT_ADD] = ff_reg[gi];
        end
    endgenerate

endmodule
